trdb_packet_reader: RTL and testbench
=====================================

Name: trdb_packet_reader

Overview:
- Receiving end of the trace encoder's packet word stream.
- Consumes 32-bit packet words over a valid/ready handshake, decodes the header word, and reassembles complete packets.
- Presents each packet as one wide beat to a downstream sink (trace RAM writer or bench scoreboard).
- Detects malformed headers, drops those packets, and keeps packet/error counters.

Parameters:
- MAX_WORDS, 4, maximum packet length in 32-bit words (header word included); legal range 2..15.
- CNT_W, 16, width of the packet and error counters.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- clear_i  in  1  synchronous soft clear; same effect as rst_i.
- word_i  in  32  packet word from the encoder.
- word_valid_i  in  1  word_i valid.
- word_ready_o  out  1  reader accepts word_i.
- pkt_o  out  32*MAX_WORDS  assembled packet; word k at bits [32k+31:32k], header word at k=0.
- pkt_words_o  out  4  number of valid words in pkt_o.
- pkt_type_o  out  2  msg_type from header bits [5:4].
- pkt_valid_o  out  1  pkt_o holds a complete packet.
- pkt_ready_i  in  1  sink accepts the packet.
- err_o  out  1  one-cycle pulse on each malformed header.
- pkt_cnt_o  out  CNT_W  number of packets delivered.
- err_cnt_o  out  CNT_W  number of malformed headers.

Behaviour:
- Transfer rule: a word transfers when word_valid_i && word_ready_o; a packet transfers when pkt_valid_o && pkt_ready_i.
- Header format:
  - bits [3:0] = W, the total word count including the header.
  - bits [5:4] = msg_type.
  - the remaining bits are payload and are passed through unchanged.
- Reset and clear (rst_i or clear_i, synchronous, applied mid-operation too):
  - state becomes HDR;
  - pkt_valid_o=0, err_o=0, pkt_o=0, pkt_words_o=0, pkt_type_o=0, both counters=0;
  - word_ready_o=1 from the first cycle after reset.
  - Any partial packet is discarded without raising an error.
- State HDR (word_ready_o=1):
  - W==1: store the word, set pkt_words_o=1, go to OUT.
  - 2<=W<=MAX_WORDS: store the header, set the word index to 1, go to COL.
  - W==0: pulse err_o, increment err_cnt_o, stay in HDR.
  - W>MAX_WORDS: pulse err_o, increment err_cnt_o, load the drop counter with W-1, go to DROP.
- State COL (word_ready_o=1):
  - Each accepted word is stored at the current index, and the index increments.
  - When the index reaches W-1 and that word is accepted, go to OUT; pkt_valid_o rises the next cycle.
  - Unused upper words of pkt_o are driven to 0.
- State DROP (word_ready_o=1): accepted words are discarded and the drop counter decrements; return to HDR when the last word is accepted.
- State OUT:
  - word_ready_o=0 and pkt_valid_o=1.
  - pkt_o, pkt_words_o and pkt_type_o are held stable until the transfer.
  - On transfer: pkt_cnt_o increments, pkt_valid_o falls the next cycle, go to HDR.
  - No skid buffer: there is one idle word slot per packet.
- Latency: pkt_valid_o asserts one cycle after the last word of a packet is accepted.
- Counters saturate at all-ones and never wrap.
- word_valid_i low in any state means no state change; gaps between words are legal.
- word_i is ignored when word_valid_i=0.
- err_o is registered; it is high exactly one cycle, in the cycle after the bad header is accepted.

Test Plan:
- Single-word packets: 0x00000011 followed by 0x000000A1, sink always ready.
  - pkt_o word0=0x11 with words=1, type=1; then word0=0xA1 with words=1, type=2.
  - pkt_cnt_o=2 and err_o never asserted.
- Full packet with sink backpressure: header 0x00000024, then 0xDEADBEEF, 0x12345678, 0xCAFEF00D, with pkt_ready_i low for 5 cycles.
  - pkt_o = {0xCAFEF00D, 0x12345678, 0xDEADBEEF, 0x00000024}, words=4, type=2.
  - pkt_o stays stable and word_ready_o=0 throughout the stall; pkt_cnt_o=1 after the accept.
- Zero-length header: 0x00000000 then 0x00000002, 0x55.
  - One err_o pulse and err_cnt_o=1.
  - Next packet = {0x55, 0x02}, words=2.
- Oversize header: 0x00000006 with MAX_WORDS=4, followed by 5 words, then header 0x00000001.
  - One err_o pulse and all 5 words dropped.
  - Next packet = 0x00000001, words=1; err_cnt_o=1 and pkt_cnt_o=1.
- Reset mid-operation: header 0x3 and one word, then rst_i for 1 cycle, then header 0x2 and word 0x77.
  - Output {0x77, 0x02}, pkt_cnt_o=1, err_cnt_o=0.
- Gapped input: header 0x3 and 2 words with word_valid_i low 3 cycles between each.
  - pkt_valid_o asserts exactly 1 cycle after the last word is accepted.

Source files
------------

// File: rtl/trdb_packet_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | trdb_packet_reader: reassembles trace packet words into one wide beat.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module trdb_packet_reader #(
  parameter int MAX_WORDS = 4,
  parameter int CNT_W     = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clear_i,
  input  logic [31:0]            word_i,
  input  logic                   word_valid_i,
  output logic                   word_ready_o,
  output logic [32*MAX_WORDS-1:0] pkt_o,
  output logic [3:0]             pkt_words_o,
  output logic [1:0]             pkt_type_o,
  output logic                   pkt_valid_o,
  input  logic                   pkt_ready_i,
  output logic                   err_o,
  output logic [CNT_W-1:0]       pkt_cnt_o,
  output logic [CNT_W-1:0]       err_cnt_o
);

  localparam logic [3:0] c_max_words = 4'(MAX_WORDS);

  typedef enum logic [1:0] {S_HDR, S_COL, S_DROP, S_OUT} state_t;

  state_t                 r_state;
  logic [32*MAX_WORDS-1:0] r_pkt;
  logic [3:0]             r_words;
  logic [1:0]             r_type;
  logic                   r_valid;
  logic                   r_ready;
  logic                   r_err;
  logic [3:0]             r_idx;
  logic [3:0]             r_drop;
  logic [CNT_W-1:0]       r_pkt_cnt;
  logic [CNT_W-1:0]       r_err_cnt;

  logic       w_word_fire;
  logic [3:0] w_len;

  assign w_word_fire = word_valid_i && r_ready;
  assign w_len       = word_i[3:0];

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_state   <= S_HDR;
      r_pkt     <= '0;
      r_words   <= '0;
      r_type    <= '0;
      r_valid   <= 1'b0;
      r_ready   <= 1'b1;
      r_err     <= 1'b0;
      r_idx     <= '0;
      r_drop    <= '0;
      r_pkt_cnt <= '0;
      r_err_cnt <= '0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_HDR: begin
          if (w_word_fire) begin
            if (w_len == 4'd0) begin
              r_err <= 1'b1;
              if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + CNT_W'(1);
            end else if (w_len > c_max_words) begin
              r_err  <= 1'b1;
              if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + CNT_W'(1);
              r_drop <= w_len - 4'd1;
              r_state <= S_DROP;
            end else begin
              // Zero-extending clears stale upper words from the previous packet.
              r_pkt   <= (32*MAX_WORDS)'(word_i);
              r_words <= w_len;
              r_type  <= word_i[5:4];
              r_idx   <= 4'd1;
              if (w_len == 4'd1) begin
                r_state <= S_OUT;
                r_valid <= 1'b1;
                r_ready <= 1'b0;
              end else begin
                r_state <= S_COL;
              end
            end
          end
        end
        S_COL: begin
          if (w_word_fire) begin
            for (int k = 1; k < MAX_WORDS; k++) begin
              if (r_idx == 4'(k)) r_pkt[32*k +: 32] <= word_i;
            end
            r_idx <= r_idx + 4'd1;
            if (r_idx == r_words - 4'd1) begin
              r_state <= S_OUT;
              r_valid <= 1'b1;
              r_ready <= 1'b0;
            end
          end
        end
        S_DROP: begin
          if (w_word_fire) begin
            if (r_drop == 4'd1) r_state <= S_HDR;
            else                r_drop  <= r_drop - 4'd1;
          end
        end
        S_OUT: begin
          if (pkt_ready_i) begin
            r_state <= S_HDR;
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            if (r_pkt_cnt != '1) r_pkt_cnt <= r_pkt_cnt + CNT_W'(1);
          end
        end
        default: r_state <= S_HDR;
      endcase
    end
  end

  assign word_ready_o = r_ready;
  assign pkt_o        = r_pkt;
  assign pkt_words_o  = r_words;
  assign pkt_type_o   = r_type;
  assign pkt_valid_o  = r_valid;
  assign err_o        = r_err;
  assign pkt_cnt_o    = r_pkt_cnt;
  assign err_cnt_o    = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_trdb_packet_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_trdb_packet_reader: directed self-checking bench for the packet reader|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_trdb_packet_reader;

  localparam int MAX_WORDS = 4;
  localparam int CNT_W     = 16;

  logic                    clk_i = 1'b0;
  logic                    rst_i = 1'b1;
  logic                    clear_i = 1'b0;
  logic [31:0]             word_i = 32'hFFFF_FFFF;
  logic                    word_valid_i = 1'b0;
  logic                    word_ready_o;
  logic [32*MAX_WORDS-1:0] pkt_o;
  logic [3:0]              pkt_words_o;
  logic [1:0]              pkt_type_o;
  logic                    pkt_valid_o;
  logic                    pkt_ready_i = 1'b0;
  logic                    err_o;
  logic [CNT_W-1:0]        pkt_cnt_o;
  logic [CNT_W-1:0]        err_cnt_o;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_err_pulses = 0;

  trdb_packet_reader #(.MAX_WORDS(MAX_WORDS), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i),
    .word_i(word_i), .word_valid_i(word_valid_i), .word_ready_o(word_ready_o),
    .pkt_o(pkt_o), .pkt_words_o(pkt_words_o), .pkt_type_o(pkt_type_o),
    .pkt_valid_o(pkt_valid_o), .pkt_ready_i(pkt_ready_i),
    .err_o(err_o), .pkt_cnt_o(pkt_cnt_o), .err_cnt_o(err_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) if (err_o === 1'b1) n_err_pulses++;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Junk is left on word_i while invalid so an unmasked read would look like a bad header.
  task automatic send(input logic [31:0] w);
    int n;
    n = 0;
    @(negedge clk_i);
    word_i = w;
    word_valid_i = 1'b1;
    while (word_ready_o !== 1'b1 && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    check("send_ready", word_ready_o, 1);
    @(posedge clk_i);
    #1;
    word_valid_i = 1'b0;
    word_i = 32'hFFFF_FFFF;
  endtask

  task automatic check_pkt(input string tag, input logic [127:0] exp_pkt,
                           input logic [3:0] exp_words, input logic [1:0] exp_type);
    @(negedge clk_i);
    check({tag, "_valid"}, pkt_valid_o, 1);
    check({tag, "_pkt"}, pkt_o, exp_pkt);
    check({tag, "_words"}, pkt_words_o, exp_words);
    check({tag, "_type"}, pkt_type_o, exp_type);
  endtask

  task automatic accept();
    @(negedge clk_i);
    pkt_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    pkt_ready_i = 1'b0;
  endtask

  task automatic soft_clear();
    @(negedge clk_i);
    clear_i = 1'b1;
    @(negedge clk_i);
    clear_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    check("rst_ready", word_ready_o, 1);
    check("rst_valid", pkt_valid_o, 0);
    check("rst_pkt", pkt_o, 0);
    check("rst_words", pkt_words_o, 0);
    check("rst_err", err_o, 0);
    check("rst_pkt_cnt", pkt_cnt_o, 0);
    check("rst_err_cnt", err_cnt_o, 0);

    // Single-word packets back to back.
    send(32'h0000_0011);
    check_pkt("single0", 128'h11, 4'd1, 2'd1);
    accept();
    send(32'h0000_00A1);
    check_pkt("single1", 128'hA1, 4'd1, 2'd2);
    accept();
    @(negedge clk_i);
    check("single_cnt", pkt_cnt_o, 2);
    check("single_noerr", n_err_pulses, 0);

    // Full-length packet held under sink backpressure.
    soft_clear();
    check("clear_cnt", pkt_cnt_o, 0);
    send(32'h0000_0024);
    send(32'hDEAD_BEEF);
    send(32'h1234_5678);
    send(32'hCAFE_F00D);
    check_pkt("full", {32'hCAFE_F00D, 32'h1234_5678, 32'hDEAD_BEEF, 32'h0000_0024}, 4'd4, 2'd2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      check("stall_pkt", pkt_o, {32'hCAFE_F00D, 32'h1234_5678, 32'hDEAD_BEEF, 32'h0000_0024});
      check("stall_ready", word_ready_o, 0);
      check("stall_valid", pkt_valid_o, 1);
    end
    accept();
    @(negedge clk_i);
    check("full_cnt", pkt_cnt_o, 1);
    check("full_valid_fall", pkt_valid_o, 0);

    // Gapped 3-word packet; the stale fourth word must read back as zero.
    send(32'h0000_0003);
    repeat (3) @(negedge clk_i);
    check("gap_valid0", pkt_valid_o, 0);
    send(32'h0000_1111);
    repeat (3) @(negedge clk_i);
    check("gap_valid1", pkt_valid_o, 0);
    send(32'h0000_2222);
    check_pkt("gap", {32'h0, 32'h0000_2222, 32'h0000_1111, 32'h0000_0003}, 4'd3, 2'd0);
    accept();

    // Zero-length header.
    soft_clear();
    base = n_err_pulses;
    send(32'h0000_0000);
    @(negedge clk_i);
    check("zero_err_pulse", err_o, 1);
    @(negedge clk_i);
    check("zero_err_low", err_o, 0);
    send(32'h0000_0002);
    send(32'h0000_0055);
    check_pkt("zero_next", {32'h0, 32'h0, 32'h0000_0055, 32'h0000_0002}, 4'd2, 2'd0);
    check("zero_err_cnt", err_cnt_o, 1);
    check("zero_pulses", n_err_pulses - base, 1);
    accept();

    // Oversize header: five trailing words are swallowed.
    soft_clear();
    base = n_err_pulses;
    send(32'h0000_0006);
    @(negedge clk_i);
    check("over_err_pulse", err_o, 1);
    for (int i = 0; i < 5; i++) send(32'h0000_0101 + i);
    send(32'h0000_0001);
    check_pkt("over_next", 128'h1, 4'd1, 2'd0);
    accept();
    @(negedge clk_i);
    check("over_err_cnt", err_cnt_o, 1);
    check("over_pkt_cnt", pkt_cnt_o, 1);
    check("over_pulses", n_err_pulses - base, 1);

    // Hard reset in the middle of a packet.
    send(32'h0000_0003);
    send(32'h0000_00AA);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    check("mid_rst_ready", word_ready_o, 1);
    check("mid_rst_cnt", pkt_cnt_o, 0);
    base = n_err_pulses;
    send(32'h0000_0002);
    send(32'h0000_0077);
    check_pkt("mid_rst", {32'h0, 32'h0, 32'h0000_0077, 32'h0000_0002}, 4'd2, 2'd0);
    accept();
    @(negedge clk_i);
    check("mid_rst_pkt_cnt", pkt_cnt_o, 1);
    check("mid_rst_err_cnt", err_cnt_o, 0);
    check("mid_rst_pulses", n_err_pulses - base, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
